led_pwm_periph: RTL and testbench

LED_PWM_PERIPH -- requirements
Module: led_pwm_periph

---
 rtl/led_pwm_pkg.sv | 21 ++
 rtl/led_pwm_periph_if.sv | 15 +
 rtl/led_pwm_timebase.sv | 33 +++
 rtl/led_pwm_periph.sv | 148 ++++++++++++++
 tb/tb_led_pwm_periph.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// Shared register map and channel mode encoding for the LED PWM peripheral.
package led_pwm_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_PWM    = 1'b1
  } led_mode_e;

  // Word offsets (addr[7:2]); byte addresses are 0x00, 0x04, 0x08, 0x10+4*i
  localparam logic [5:0] OFF_OUT      = 6'h00;
  localparam logic [5:0] OFF_MODE     = 6'h01;
  localparam logic [5:0] OFF_PRESCALE = 6'h02;
  localparam logic [5:0] OFF_DUTY0    = 6'h04;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_periph_if.sv
// Single-cycle-grant register bus used to talk to the LED PWM peripheral.
interface led_pwm_periph_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, err, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/led_pwm_timebase.sv
// Prescaler plus free-running PWM period counter; wrap marks the start of a period.
module led_pwm_timebase #(
  parameter int PwmWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [15:0]         prescale_i,
  input  logic                clr_i,
  output logic                tick_o,
  output logic                wrap_o,
  output logic [PwmWidth-1:0] period_o
);

  logic [15:0]         presc_q;
  logic [PwmWidth-1:0] period_q;

  assign tick_o   = (presc_q == prescale_i);
  assign wrap_o   = tick_o && (period_q == '1);
  assign period_o = period_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      period_q <= '0;
    end else begin
      // A PRESCALE write restarts the prescaler so it never sits above the new limit
      if (clr_i || tick_o) presc_q <= '0;
      else                 presc_q <= presc_q + 16'd1;
      if (tick_o) period_q <= period_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_periph.sv
// LED driver peripheral: OUT levels always; MODE/PRESCALE/DUTY PWM engine only
// when LED_PWM_PERIPH_PWM_EN is defined.
module led_pwm_periph
  import led_pwm_pkg::*;
#(
  parameter int NumLeds  = 4,
  parameter int PwmWidth = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic               err_o,
  output logic [31:0]        rdata_o,
  output logic [NumLeds-1:0] led_o
);

  logic [5:0]         off;
  logic               hit;
  logic               wr_en;
  logic [31:0]        rd_val;
  logic [31:0]        wr_word;
  logic [NumLeds-1:0] out_q;
  logic [NumLeds-1:0] led_d;
  logic [NumLeds-1:0] led_q;
  logic               rvalid_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic               unused_bits;

  assign off   = addr_i[7:2];
  assign gnt_o = req_i;
  assign wr_en = req_i & we_i & hit;
  // rd_val is the addressed register's current value, so merging lanes over it
  // yields the byte-enabled write result for whichever register is selected
  assign wr_word = (rd_val & ~be_mask(be_i)) | (wdata_i & be_mask(be_i));
  assign unused_bits = ^{addr_i[31:8], addr_i[1:0], wr_word};

`ifdef LED_PWM_PERIPH_PWM_EN
  logic [NumLeds-1:0]               mode_q;
  logic [15:0]                      prescale_q;
  logic [NumLeds-1:0][PwmWidth-1:0] duty_q;
  logic [NumLeds-1:0][PwmWidth-1:0] shadow_q;
  logic                             tick;
  logic                             wrap;
  logic [PwmWidth-1:0]              period;
  logic                             presc_wr;
  logic                             unused_tick;

  assign presc_wr    = wr_en && (off == OFF_PRESCALE);
  assign unused_tick = tick;
`endif

  always_comb begin
    hit    = 1'b0;
    rd_val = '0;
    if (off == OFF_OUT) begin
      hit    = 1'b1;
      rd_val = 32'(out_q);
    end
`ifdef LED_PWM_PERIPH_PWM_EN
    if (off == OFF_MODE) begin
      hit    = 1'b1;
      rd_val = 32'(mode_q);
    end
    if (off == OFF_PRESCALE) begin
      hit    = 1'b1;
      rd_val = 32'(prescale_q);
    end
    for (int i = 0; i < NumLeds; i++) begin
      if (off == OFF_DUTY0 + 6'(i)) begin
        hit    = 1'b1;
        rd_val = 32'(duty_q[i]);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else if (wr_en && (off == OFF_OUT)) out_q <= wr_word[NumLeds-1:0];
  end

`ifdef LED_PWM_PERIPH_PWM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q     <= '0;
      prescale_q <= '0;
      duty_q     <= '0;
      shadow_q   <= '0;
    end else begin
      if (wr_en && (off == OFF_MODE)) mode_q <= wr_word[NumLeds-1:0];
      if (presc_wr) prescale_q <= wr_word[15:0];
      for (int i = 0; i < NumLeds; i++)
        if (wr_en && (off == OFF_DUTY0 + 6'(i))) duty_q[i] <= wr_word[PwmWidth-1:0];
      // Duty changes only take effect on a period boundary to avoid glitched pulses
      if (wrap) shadow_q <= duty_q;
    end
  end

  led_pwm_timebase #(.PwmWidth(PwmWidth)) u_timebase (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .prescale_i(prescale_q),
    .clr_i     (presc_wr),
    .tick_o    (tick),
    .wrap_o    (wrap),
    .period_o  (period)
  );

  for (genvar i = 0; i < NumLeds; i++) begin : g_ch
    assign led_d[i] = (led_mode_e'(mode_q[i]) == MODE_PWM) ? (period < shadow_q[i]) : out_q[i];
  end
`else
  logic [PwmWidth-1:0] unused_pwm_w;
  logic                unused_pwm_cfg;

  // PWM-only configuration stays referenced so both builds share one source
  assign unused_pwm_w   = '0;
  assign unused_pwm_cfg = ^{OFF_MODE, OFF_PRESCALE, OFF_DUTY0, MODE_PWM, unused_pwm_w};
  assign led_d          = out_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      led_q    <= '0;
    end else begin
      rvalid_q <= req_i;
      err_q    <= req_i & ~hit;
      rdata_q  <= (req_i && !we_i && hit) ? rd_val : '0;
      led_q    <= led_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign led_o    = led_q;

endmodule

// File: tb/tb_led_pwm_periph.sv
// Directed bench for led_pwm_periph: register table plus PWM/reset sequences.
module tb_led_pwm_periph;

  localparam int NumLeds = 4;
`ifdef LED_PWM_PERIPH_PWM_EN
  localparam bit PwmEn = 1'b1;
`else
  localparam bit PwmEn = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NumLeds-1:0] led;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  vec_t vecs[22];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_pwm_periph_if bus();

  led_pwm_periph #(.NumLeds(NumLeds), .PwmWidth(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .req_i   (bus.req),
    .we_i    (bus.we),
    .be_i    (bus.be),
    .addr_i  (bus.addr),
    .wdata_i (bus.wdata),
    .gnt_o   (bus.gnt),
    .rvalid_o(bus.rvalid),
    .err_o   (bus.err),
    .rdata_o (bus.rdata),
    .led_o   (led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic bus_chk(input string nm, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    bus.req = 1'b1; bus.we = we; bus.be = be; bus.addr = addr; bus.wdata = wdata;
    #1 check({nm, " gnt"}, 32'(bus.gnt), 32'd1);
    @(posedge clk);
    #1;
    check({nm, " rvalid"}, 32'(bus.rvalid), 32'd1);
    check({nm, " err"}, 32'(bus.err), 32'(exp_err));
    check({nm, " rdata"}, bus.rdata, exp_rd);
    bus_idle();
  endtask

  task automatic wait_led0(input logic lvl, output int t);
    t = -1;
    for (int n = 0; n < 2000 && t < 0; n++) begin
      @(posedge clk);
      #1;
      if (led[0] === lvl) t = cyc;
    end
    if (t < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_led0: led[0] never reached %0b within 2000 cycles", lvl);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus_idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tr1, tf1, tr2, tf2, tr3, tf3, ta, tfa, tb;
    bus_idle();
    vecs[0]  = '{1'b1, 4'h1, 32'h00,  32'h0000000A, 1'b0,   32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h00,  32'h0,        1'b0,   32'hA};
    vecs[2]  = '{1'b1, 4'hF, 32'h3C,  32'h0000FFFF, 1'b1,   32'h0};
    vecs[3]  = '{1'b0, 4'hF, 32'h3C,  32'h0,        1'b1,   32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h00,  32'h0,        1'b0,   32'hA};
    vecs[5]  = '{1'b1, 4'h0, 32'h00,  32'h5,        1'b0,   32'h0};
    vecs[6]  = '{1'b0, 4'hF, 32'h00,  32'h0,        1'b0,   32'hA};
    vecs[7]  = '{1'b1, 4'hF, 32'h00,  32'hFFFFFFFF, 1'b0,   32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'h100, 32'h0,        1'b0,   32'hF};
    vecs[9]  = '{1'b1, 4'hE, 32'h00,  32'h0,        1'b0,   32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h00,  32'h0,        1'b0,   32'hF};
    vecs[11] = '{1'b1, 4'h1, 32'h04,  32'h0,        !PwmEn, 32'h0};
    vecs[12] = '{1'b0, 4'hF, 32'h04,  32'h0,        !PwmEn, 32'h0};
    vecs[13] = '{1'b1, 4'hF, 32'h10,  32'h1234,     !PwmEn, 32'h0};
    vecs[14] = '{1'b0, 4'hF, 32'h10,  32'h0,        !PwmEn, PwmEn ? 32'h34 : 32'h0};
    vecs[15] = '{1'b1, 4'h1, 32'h08,  32'h12345678, !PwmEn, 32'h0};
    vecs[16] = '{1'b0, 4'hF, 32'h08,  32'h0,        !PwmEn, PwmEn ? 32'h78 : 32'h0};
    vecs[17] = '{1'b1, 4'hC, 32'h08,  32'hFFFFFFFF, !PwmEn, 32'h0};
    vecs[18] = '{1'b0, 4'hF, 32'h08,  32'h0,        !PwmEn, PwmEn ? 32'h78 : 32'h0};
    vecs[19] = '{1'b0, 4'hF, 32'h1C,  32'h0,        !PwmEn, 32'h0};
    vecs[20] = '{1'b0, 4'hF, 32'h20,  32'h0,        1'b1,   32'h0};
    vecs[21] = '{1'b1, 4'h1, 32'h00,  32'h0,        1'b0,   32'h0};

    // Reset state
    #2;
    check("reset led", 32'(led), 32'h0);
    check("reset rvalid", 32'(bus.rvalid), 32'h0);
    check("reset err", 32'(bus.err), 32'h0);
    check("reset rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1 check("idle gnt", 32'(bus.gnt), 32'h0);

    foreach (vecs[i])
      bus_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
              vecs[i].err, vecs[i].rdata);

    // OUT write: led follows one cycle after the register update
    bus_chk("out 0xA", 1'b1, 4'h1, 32'h00, 32'hA, 1'b0, 32'h0);
    check("led before update", 32'(led), 32'h0);
    @(posedge clk);
    #1;
    check("led after update", 32'(led), 32'hA);
    check("rvalid drops", 32'(bus.rvalid), 32'h0);
    check("rdata idle", bus.rdata, 32'h0);
    bus_chk("read out", 1'b0, 4'hF, 32'h00, 32'h0, 1'b0, 32'hA);

`ifdef LED_PWM_PERIPH_PWM_EN
    apply_reset();
    bus_chk("mode pwm", 1'b1, 4'hF, 32'h04, 32'h1, 1'b0, 32'h0);
    bus_chk("duty 64", 1'b1, 4'hF, 32'h10, 32'd64, 1'b0, 32'h0);
    wait_led0(1'b1, tr1);
    wait_led0(1'b0, tf1);
    check("duty64 high run", 32'(tf1 - tr1), 32'd64);
    wait_led0(1'b1, tr2);
    check("duty64 low run", 32'(tr2 - tf1), 32'd192);
    bus_chk("duty 192", 1'b1, 4'hF, 32'h10, 32'd192, 1'b0, 32'h0);
    wait_led0(1'b0, tf2);
    check("old duty completes", 32'(tf2 - tr2), 32'd64);
    wait_led0(1'b1, tr3);
    check("period 256", 32'(tr3 - tr2), 32'd256);
    wait_led0(1'b0, tf3);
    check("duty192 high run", 32'(tf3 - tr3), 32'd192);
    bus_chk("prescale 3", 1'b1, 4'hF, 32'h08, 32'd3, 1'b0, 32'h0);
    wait_led0(1'b1, ta);
    wait_led0(1'b0, tfa);
    check("ps3 high run", 32'(tfa - ta), 32'd768);
    wait_led0(1'b1, tb);
    check("ps3 period", 32'(tb - ta), 32'd1024);
`endif

    // Reset asserted while a read is being accepted
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = 32'h0;
    #2 rst_ni = 1'b0;
    #1;
    check("reset led immediate", 32'(led), 32'h0);
    check("reset rvalid immediate", 32'(bus.rvalid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("dropped rvalid", 32'(bus.rvalid), 32'h0);
    check("dropped rdata", bus.rdata, 32'h0);
    repeat (300) @(posedge clk);
    #1 check("led held off", 32'(led), 32'h0);
    bus_chk("post-reset out", 1'b0, 4'hF, 32'h00, 32'h0, 1'b0, 32'h0);
    bus_chk("post-reset mode", 1'b0, 4'hF, 32'h04, 32'h0, !PwmEn, 32'h0);
    bus_chk("post-reset prescale", 1'b0, 4'hF, 32'h08, 32'h0, !PwmEn, 32'h0);
    bus_chk("post-reset duty0", 1'b0, 4'hF, 32'h10, 32'h0, !PwmEn, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
